// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : issue_queue
// Purpose  : Out-of-order issue stage. Buffers dispatched instructions, tracks
//            operand readiness with a register scoreboard, wakes entries on
//            writeback and issues the oldest ready entry to each free FU.
// Revision : 1.0 - initial release
// ============================================================================
module issue_queue #(
    parameter int DEPTH = 8,
    parameter int N_FU  = 4,
    parameter int NREGS = 32,
    parameter int PAY_W = 32,
    localparam int FW   = (N_FU > 1) ? $clog2(N_FU) : 1,
    localparam int RW   = $clog2(NREGS),
    localparam int OW   = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  flush,
    input  logic                  freeze,
    input  logic                  disp_valid,
    output logic                  disp_ready,
    input  logic [FW-1:0]         disp_fu,
    input  logic [RW-1:0]         disp_rd,
    input  logic                  disp_rd_en,
    input  logic [RW-1:0]         disp_rs1,
    input  logic [RW-1:0]         disp_rs2,
    input  logic                  disp_rs1_en,
    input  logic                  disp_rs2_en,
    input  logic [PAY_W-1:0]      disp_payload,
    input  logic                  wb_valid,
    input  logic [RW-1:0]         wb_rd,
    input  logic [N_FU-1:0]       fu_ready,
    output logic [N_FU-1:0]       iss_valid,
    output logic [N_FU*PAY_W-1:0] iss_payload,
    output logic [N_FU*RW-1:0]    iss_rd,
    output logic [N_FU-1:0]       iss_rd_en,
    output logic [OW-1:0]         occupancy
);

    localparam int IW = $clog2(DEPTH);

    // Entry storage; older[i] holds a mask of the entries that are older than i.
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] wait1;
    logic [DEPTH-1:0] wait2;
    logic [DEPTH-1:0] ent_rd_en;
    logic [FW-1:0]    ent_fu  [DEPTH];
    logic [RW-1:0]    ent_rs1 [DEPTH];
    logic [RW-1:0]    ent_rs2 [DEPTH];
    logic [RW-1:0]    ent_rd  [DEPTH];
    logic [PAY_W-1:0] ent_pay [DEPTH];
    logic [DEPTH-1:0] older   [DEPTH];
    logic [NREGS-1:0] busy;

    logic             accept;
    logic             keep;
    logic             src1_wait;
    logic             src2_wait;
    logic [IW-1:0]    free_idx;

    logic [DEPTH-1:0] elig     [N_FU];
    logic [DEPTH-1:0] pick     [N_FU];
    logic [PAY_W-1:0] pick_pay [N_FU];
    logic [RW-1:0]    pick_rd  [N_FU];
    logic [N_FU-1:0]  pick_rd_en;
    logic [N_FU-1:0]  issue;
    logic [DEPTH-1:0] remove;
    logic [OW-1:0]    n_remove;

    // Ready only looks at registered occupancy, so a slot freed this cycle is not reused yet.
    assign disp_ready = nRST && !flush && !freeze && (occupancy < OW'(DEPTH));
    assign accept     = disp_valid && disp_ready;
    // Out-of-range FU targets are swallowed: accepted but never stored.
    assign keep       = accept && ({1'b0, disp_fu} < (FW+1)'(N_FU));
    // Same-cycle writeback of a source bypasses the wait.
    assign src1_wait  = disp_rs1_en && (disp_rs1 != '0) && busy[disp_rs1]
                        && !(wb_valid && (wb_rd == disp_rs1));
    assign src2_wait  = disp_rs2_en && (disp_rs2 != '0) && busy[disp_rs2]
                        && !(wb_valid && (wb_rd == disp_rs2));

    // Lowest-index free slot receives the next accepted instruction.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) free_idx = IW'(i);
        end
    end

    // Per-FU oldest-ready select and the resulting removal mask.
    always_comb begin
        remove     = '0;
        issue      = '0;
        pick_rd_en = '0;
        n_remove   = '0;
        for (int f = 0; f < N_FU; f++) begin
            elig[f]     = '0;
            pick[f]     = '0;
            pick_pay[f] = '0;
            pick_rd[f]  = '0;
            for (int i = 0; i < DEPTH; i++) begin
                elig[f][i] = valid[i] && !wait1[i] && !wait2[i] && (ent_fu[i] == FW'(f));
            end
            for (int i = 0; i < DEPTH; i++) begin
                pick[f][i] = elig[f][i] && ((elig[f] & older[i]) == '0);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (pick[f][i]) begin
                    pick_pay[f]   = ent_pay[i];
                    pick_rd[f]    = ent_rd[i];
                    pick_rd_en[f] = ent_rd_en[i];
                end
            end
            issue[f] = (|pick[f]) && fu_ready[f] && !freeze && !flush;
            if (issue[f]) begin
                remove   = remove | pick[f];
                n_remove = n_remove + OW'(1);
            end
        end
    end

    // Entry array: removal, writeback wakeup, then allocation of the new entry.
    always_ff @(posedge CLK) begin
        if (!nRST || flush) begin
            valid <= '0;
            wait1 <= '0;
            wait2 <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (remove[i]) valid[i] <= 1'b0;
                if (wb_valid && (ent_rs1[i] == wb_rd)) wait1[i] <= 1'b0;
                if (wb_valid && (ent_rs2[i] == wb_rd)) wait2[i] <= 1'b0;
            end
            if (keep) begin
                valid[free_idx]     <= 1'b1;
                wait1[free_idx]     <= src1_wait;
                wait2[free_idx]     <= src2_wait;
                ent_fu[free_idx]    <= disp_fu;
                ent_rs1[free_idx]   <= disp_rs1;
                ent_rs2[free_idx]   <= disp_rs2;
                ent_rd[free_idx]    <= disp_rd;
                ent_rd_en[free_idx] <= disp_rd_en;
                ent_pay[free_idx]   <= disp_payload;
                older[free_idx]     <= valid;
                for (int j = 0; j < DEPTH; j++) begin
                    older[j][free_idx] <= 1'b0;
                end
            end
        end
    end

    // Scoreboard and occupancy; a set on accept overrides a same-cycle writeback clear.
    always_ff @(posedge CLK) begin
        if (!nRST || flush) begin
            busy      <= '0;
            occupancy <= '0;
        end else begin
            if (wb_valid) busy[wb_rd] <= 1'b0;
            if (keep && disp_rd_en && (disp_rd != '0)) busy[disp_rd] <= 1'b1;
            occupancy <= occupancy + OW'(keep) - n_remove;
        end
    end

    // Issue outputs: one-cycle strobes, held during freeze, dropped on flush.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            iss_valid   <= '0;
            iss_payload <= '0;
            iss_rd      <= '0;
            iss_rd_en   <= '0;
        end else if (flush) begin
            iss_valid <= '0;
        end else if (!freeze) begin
            iss_valid <= issue;
            for (int f = 0; f < N_FU; f++) begin
                if (issue[f]) begin
                    iss_payload[f*PAY_W +: PAY_W] <= pick_pay[f];
                    iss_rd[f*RW +: RW]            <= pick_rd[f];
                    iss_rd_en[f]                  <= pick_rd_en[f];
                end
            end
        end
    end

endmodule
`default_nettype wire
